pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Multi-channel event-to-level driver for the I/O block. It turns single-cycle event pulses (button presses, UART strobes, CPU GPIO writes) into fixed-length, human- or peripheral-visible output pulses separated by a guaranteed low gap. Each channel queues events that arrive while it is busy, up to a saturating depth, and flags overflow. It sits between the core/IO logic and the LED/GPIO pins, acting as the output-side counterpart to the input-side saturating-count debounce path.

## Interface

Parameters:
- N_CH, 4, number of independent channels
- WIDTH, 16, per-channel timer width
- HIGH_CYCLES, 65000, cycles each output pulse is held high; 1 ≤ HIGH_CYCLES < 2^WIDTH
- GAP_CYCLES, 65000, minimum low cycles after every pulse; 1 ≤ GAP_CYCLES < 2^WIDTH
- QUEUE_MAX, 7, maximum pending events per channel; ≥ 1

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- in  input  N_CH  per-channel event strobe, sampled each rising edge; a high level on k consecutive edges counts as k events
- clear_overflow  input  1  clears all overflow flags
- out  output  N_CH  stretched pulses, registered
- busy  output  N_CH  channel not IDLE, registered
- overflow  output  N_CH  sticky per-channel event-lost flag, registered

## Operation

- Per channel: FSM {IDLE, HIGH, GAP}, down-timer tmr[WIDTH-1:0], pending counter pend (width clog2(QUEUE_MAX+1)).
- IDLE, in=1: → HIGH, tmr ← HIGH_CYCLES-1, pend unchanged.
- HIGH: out=1; tmr decrements; at tmr==0 → GAP, tmr ← GAP_CYCLES-1.
- GAP: out=0; tmr decrements; at tmr==0:
  - pend>0 → HIGH, tmr ← HIGH_CYCLES-1, pend−1.
  - pend==0 → IDLE.
- in=1 while HIGH or GAP (not at the dequeue edge): pend+1 if pend<QUEUE_MAX; else pend holds and overflow ← 1.
- in=1 at the GAP-end edge with pend>0: increment and dequeue cancel, so pend is unchanged and no overflow, even at QUEUE_MAX.
- in=1 at the GAP-end edge with pend==0: → HIGH directly (the event is consumed, nothing queued).
- overflow: set has priority over clear_overflow in the same cycle; clear acts on all channels.
- busy = (state != IDLE).
- Channels are fully independent; no shared arbitration.
- Reset (rst=0, asynchronous): state IDLE, tmr 0, pend 0, out 0, busy 0, overflow 0. Applies mid-pulse; queued events are discarded and never replayed.

## Timing

- Event sampled at edge k → out high from edge k+1 through edge k+HIGH_CYCLES (exactly HIGH_CYCLES cycles), low for the next GAP_CYCLES cycles.
- Back-to-back queued pulses: rising edges of out are HIGH_CYCLES+GAP_CYCLES cycles apart.
- busy is high for HIGH_CYCLES+GAP_CYCLES cycles per pulse, starting the same cycle out rises.
- Output latency from in to out is 1 cycle; no combinational path from any input to any output.
- overflow rises 1 cycle after the lost event's edge.

## Test plan

Bench parameters: N_CH=4, WIDTH=4, HIGH_CYCLES=3, GAP_CYCLES=2, QUEUE_MAX=2.

- in[0] pulsed at edge 10 only → out[0]=1 after edges 11–13, 0 after 14; busy[0]=1 after edges 11–15, 0 after 16; overflow=0.
- in[1] high on edges 10, 11, 12 → out[1] high after edges 11–13, 16–18, 21–23; pend peaks at 2; overflow[1]=0; busy[1] drops after edge 26.
- in[2] high on edges 10–13 (4 events) → 3 pulses emitted, overflow[2]=1 after edge 13. clear_overflow at edge 20 → 0 after edge 20. Clear together with a new lost event → stays 1.
- Fill pend[3]=2, pulse in[3] exactly on the GAP-end edge → pend stays 2, overflow[3]=0, total pulses = 1 + 3.
- rst=0 asynchronously mid-HIGH with pend=2 → out, busy, and overflow go 0 immediately. After release, one in pulse → exactly one 3-cycle pulse, no replays.
- All four in lines pulsed on the same edge → four identical, aligned out pulses.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Multi-channel event-to-level driver: each input strobe becomes a fixed-length
// high pulse followed by a guaranteed low gap, with a saturating per-channel event queue.
module pulse_stretcher #(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int HIGH_CYCLES = 65000,
    parameter int GAP_CYCLES  = 65000,
    parameter int QUEUE_MAX   = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    input  logic            clear_overflow,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] overflow
);

    localparam int PW = (QUEUE_MAX > 0) ? $clog2(QUEUE_MAX + 1) : 1;

    localparam logic [WIDTH-1:0] HIGH_RELOAD = WIDTH'(HIGH_CYCLES - 1);
    localparam logic [WIDTH-1:0] GAP_RELOAD  = WIDTH'(GAP_CYCLES - 1);
    localparam logic [WIDTH-1:0] TMR_ONE     = WIDTH'(1);
    localparam logic [PW-1:0]    PEND_ONE    = PW'(1);
    localparam logic [PW-1:0]    PEND_MAX    = PW'(QUEUE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] tmr;
        logic [PW-1:0]    pend;
        logic             out_q;
        logic             busy_q;
        logic             ovf_q;

        logic ev;
        logic tmr_done;
        logic at_gap_end;
        logic pend_empty;
        logic pend_full;
        logic lost;

        assign ev         = in[ch];
        assign tmr_done   = (tmr == '0);
        assign at_gap_end = (state == GAP) && tmr_done;
        assign pend_empty = (pend == '0);
        assign pend_full  = (pend == PEND_MAX);
        // The GAP-end edge always absorbs a new event (start or cancel), so it is never lost.
        assign lost       = ev && (state != IDLE) && !at_gap_end && pend_full;

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order in this block.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state  <= IDLE;
                tmr    <= '0;
                pend   <= '0;
                out_q  <= 1'b0;
                busy_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ev) begin
                            state <= HIGH;
                            tmr   <= HIGH_RELOAD;
                        end
                    end
                    HIGH: begin
                        if (tmr_done) begin
                            state <= GAP;
                            tmr   <= GAP_RELOAD;
                        end else begin
                            tmr <= tmr - TMR_ONE;
                        end
                    end
                    GAP: begin
                        if (!tmr_done) begin
                            tmr <= tmr - TMR_ONE;
                        end else if (ev || !pend_empty) begin
                            state <= HIGH;
                            tmr   <= HIGH_RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tmr   <= '0;
                    end
                endcase

                if (at_gap_end) begin
                    if (!pend_empty && !ev) begin
                        pend <= pend - PEND_ONE;
                    end
                end else if (ev && (state != IDLE) && !pend_full) begin
                    pend <= pend + PEND_ONE;
                end

                if (lost) begin
                    ovf_q <= 1'b1;
                end else if (clear_overflow) begin
                    ovf_q <= 1'b0;
                end

                // Outputs trail the FSM by one edge so they come straight from flops.
                out_q  <= (state == HIGH);
                busy_q <= (state != IDLE);
            end
        end

        assign out[ch]      = out_q;
        assign busy[ch]     = busy_q;
        assign overflow[ch] = ovf_q;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a per-edge vector table for the multi-channel
// scenario, then hand sequences for overflow/clear priority, async reset and aligned restarts.
module tb_pulse_stretcher;

    localparam int N_CH  = 4;
    localparam int N_VEC = 34;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] in_v;
    logic            clr;
    logic [N_CH-1:0] out_v;
    logic [N_CH-1:0] busy_v;
    logic [N_CH-1:0] ovf_v;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [N_CH-1:0] in;
        logic            clr;
        logic [N_CH-1:0] exp_out;
        logic [N_CH-1:0] exp_busy;
        logic [N_CH-1:0] exp_ovf;
    } vec_t;

    vec_t vecs [N_VEC];

    pulse_stretcher #(
        .N_CH       (4),
        .WIDTH      (4),
        .HIGH_CYCLES(3),
        .GAP_CYCLES (2),
        .QUEUE_MAX  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (in_v),
        .clear_overflow(clr),
        .out           (out_v),
        .busy          (busy_v),
        .overflow      (ovf_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int step_no,
                         input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %b, expected %b", name, step_no, act, exp);
        end
    endtask

    task automatic step(input logic [N_CH-1:0] in_val, input logic clr_val);
        in_v = in_val;
        clr  = clr_val;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_cnt;
        int busy_cnt;
        logic [N_CH-1:0] exp_o;
        logic [N_CH-1:0] exp_b;

        // Edge e of the table: inputs held across edge e, outputs sampled just after it.
        for (int e = 0; e < N_VEC; e++) begin
            vecs[e].in[0]  = (e == 10);
            vecs[e].in[1]  = (e >= 10 && e <= 12);
            vecs[e].in[2]  = (e >= 10 && e <= 13);
            vecs[e].in[3]  = (e >= 10 && e <= 12) || (e == 15);
            vecs[e].clr    = (e == 20);

            vecs[e].exp_out[0] = (e >= 11 && e <= 13);
            vecs[e].exp_out[1] = (e >= 11 && e <= 13) || (e >= 16 && e <= 18) || (e >= 21 && e <= 23);
            vecs[e].exp_out[2] = vecs[e].exp_out[1];
            vecs[e].exp_out[3] = vecs[e].exp_out[1] || (e >= 26 && e <= 28);

            vecs[e].exp_busy[0] = (e >= 11 && e <= 15);
            vecs[e].exp_busy[1] = (e >= 11 && e <= 25);
            vecs[e].exp_busy[2] = (e >= 11 && e <= 25);
            vecs[e].exp_busy[3] = (e >= 11 && e <= 30);

            vecs[e].exp_ovf    = '0;
            vecs[e].exp_ovf[2] = (e >= 13 && e <= 19);
        end

        rst  = 1'b0;
        in_v = '0;
        clr  = 1'b0;
        #1;
        check("reset_out", 0, out_v, 4'b0000);
        check("reset_busy", 0, busy_v, 4'b0000);
        check("reset_ovf", 0, ovf_v, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int e = 0; e < N_VEC; e++) begin
            step(vecs[e].in, vecs[e].clr);
            check("tbl_out", e, out_v, vecs[e].exp_out);
            check("tbl_busy", e, busy_v, vecs[e].exp_busy);
            check("tbl_ovf", e, ovf_v, vecs[e].exp_ovf);
        end

        // Overflow set wins over a simultaneous clear; a later lone clear drops it.
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0100, 1'b0);
        check("fill_no_ovf", 0, ovf_v, 4'b0000);
        step(4'b0100, 1'b1);
        check("set_beats_clear", 1, ovf_v, 4'b0100);
        step(4'b0000, 1'b1);
        check("clear_alone", 2, ovf_v, 4'b0000);
        repeat (20) step(4'b0000, 1'b0);
        check("drain_idle", 3, busy_v, 4'b0000);

        // Async reset mid-HIGH on ch1 with a full queue and overflow already set.
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        in_v = '0;
        check("pre_rst_out", 0, out_v, 4'b0010);
        check("pre_rst_ovf", 0, ovf_v, 4'b0010);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out", 1, out_v, 4'b0000);
        check("async_rst_busy", 1, busy_v, 4'b0000);
        check("async_rst_ovf", 1, ovf_v, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(4'b0000, 1'b0);
            check("no_replay_busy", k, busy_v, 4'b0000);
        end
        hi_cnt   = 0;
        busy_cnt = 0;
        for (int k = 0; k < 14; k++) begin
            step((k == 0) ? 4'b0010 : 4'b0000, 1'b0);
            if (out_v[1]) hi_cnt++;
            if (busy_v[1]) busy_cnt++;
        end
        check("post_rst_high_cycles", 0, 4'(hi_cnt), 4'd3);
        check("post_rst_busy_cycles", 0, 4'(busy_cnt), 4'd5);
        check("post_rst_idle", 0, busy_v, 4'b0000);

        // All channels together, re-triggered exactly on the GAP-end edge with nothing queued.
        for (int k = 0; k < 13; k++) begin
            step((k == 0 || k == 5) ? 4'b1111 : 4'b0000, 1'b0);
            exp_o = ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)) ? 4'b1111 : 4'b0000;
            exp_b = (k >= 1 && k <= 10) ? 4'b1111 : 4'b0000;
            check("aligned_out", k, out_v, exp_o);
            check("aligned_busy", k, busy_v, exp_b);
            check("aligned_ovf", k, ovf_v, 4'b0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
